// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared widths and the per-stage pipeline record for the
//               alignment right shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 8;
    localparam int NSTAGE  = 5;
    localparam int REM_W   = 5;

    // shamt_rem holds the shift bits not yet consumed; bit 0 is always the
    // next stage's bit.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              sticky;
        logic [REM_W-1:0]  shamt_rem;
    } stage_t;

    function automatic logic [DATA_W-1:0] low_mask(input int unsigned width);
        return (DATA_W'(1) << width) - DATA_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rshift_stage.sv
// ============================================================================
// Module      : rshift_stage
// Description : One right-shift-by-2^K stage with sticky accumulation and an
//               enable-gated pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rshift_stage
    import fp_pkg::*;
#(
    parameter int K     = 0,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  stage_t           i_stage,
    input  logic [TAG_W-1:0] i_tag,
    output stage_t           o_stage,
    output logic [TAG_W-1:0] o_tag
);

    localparam int                 c_SH   = 1 << K;
    localparam logic [DATA_W-1:0]  c_MASK = low_mask(c_SH);

    stage_t           w_next;
    stage_t           r_stage;
    logic [TAG_W-1:0] r_tag;

    always_comb begin
        w_next           = i_stage;
        w_next.shamt_rem = i_stage.shamt_rem >> 1;
        if (i_stage.shamt_rem[0]) begin
            w_next.data   = i_stage.data >> c_SH;
            w_next.sticky = i_stage.sticky | (|(i_stage.data & c_MASK));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_stage <= w_next;
            r_tag   <= i_tag;
        end
    end

    assign o_stage = r_stage;
    assign o_tag   = r_tag;

endmodule

`default_nettype wire

// File: rtl/fp_align_rshift.sv
// ============================================================================
// Module      : fp_align_rshift
// Description : Five-stage pipelined 32-bit logical right shifter with sticky
//               output and uniform-stall valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_align_rshift
    import fp_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    stage_t           w_pipe [0:NSTAGE];
    logic [TAG_W-1:0] w_tag  [0:NSTAGE];
    logic             w_en;
    logic             w_big;
    logic             w_unused_rem;

    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    // Saturated shifts are resolved up front: zero data, sticky from the whole
    // word, and no remaining shift bits so later stages pass it through.
    assign w_big               = |in_shamt[SHAMT_W-1:5];
    assign w_pipe[0].valid     = in_valid;
    assign w_pipe[0].data      = w_big ? '0 : in_data;
    assign w_pipe[0].sticky    = w_big & (|in_data);
    assign w_pipe[0].shamt_rem = w_big ? '0 : in_shamt[4:0];
    assign w_tag[0]            = in_tag;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        rshift_stage #(
            .K     (k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_stage (w_pipe[k]),
            .i_tag   (w_tag[k]),
            .o_stage (w_pipe[k+1]),
            .o_tag   (w_tag[k+1])
        );
    end

    assign out_valid    = w_pipe[NSTAGE].valid;
    assign out_data     = w_pipe[NSTAGE].data;
    assign out_sticky   = w_pipe[NSTAGE].sticky;
    assign out_tag      = w_tag[NSTAGE];
    assign w_unused_rem = |w_pipe[NSTAGE].shamt_rem;

endmodule

`default_nettype wire

// File: tb/tb_fp_align_rshift.sv
// ============================================================================
// Module      : tb_fp_align_rshift
// Description : Self-checking bench for fp_align_rshift with directed and
//               random traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_align_rshift;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_shamt = '0;
    logic [7:0]  in_tag = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sticky;
    logic [7:0]  out_tag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ir_low = 0;
    bit lat_chk = 1'b0;
    bit accepted;

    logic [31:0] q_data [$];
    logic        q_sticky [$];
    logic [7:0]  q_tag [$];
    int          q_cyc [$];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_sticky;
    logic [7:0]  prev_tag;

    fp_align_rshift #(.TAG_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdl_data(input logic [31:0] d, input int s);
        if (s >= 32) return 32'd0;
        return d >> s;
    endfunction

    function automatic logic mdl_sticky(input logic [31:0] d, input int s);
        logic [63:0] m;
        if (s >= 32) return |d;
        m = (64'd1 << s) - 64'd1;
        return |({32'd0, d} & m);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Called just after a falling edge; drives one cycle, checks, then waits
    // for the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] s,
                         input logic [7:0] t, input logic ordy, input bit has_exp,
                         input logic [31:0] ed, input logic es);
        logic        exp_ir;
        logic [31:0] e_d;
        logic        e_s;
        logic [7:0]  e_t;
        int          e_c;
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_tag    = t;
        out_ready = ordy;
        #1;
        exp_ir = !(out_valid && !ordy);
        chk("in_ready", in_ready, exp_ir);
        if (!in_ready) ir_low++;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_sticky", out_sticky, prev_sticky);
            chk("stall_tag", out_tag, prev_tag);
        end
        if (out_valid && ordy) begin
            if (q_data.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e_d = q_data.pop_front();
                e_s = q_sticky.pop_front();
                e_t = q_tag.pop_front();
                e_c = q_cyc.pop_front();
                chk("out_data", out_data, e_d);
                chk("out_sticky", out_sticky, e_s);
                chk("out_tag", out_tag, e_t);
                if (lat_chk) chk("latency", cyc - e_c, 5);
            end
        end
        prev_stall  = out_valid && !ordy;
        prev_data   = out_data;
        prev_sticky = out_sticky;
        prev_tag    = out_tag;
        accepted = v && in_ready;
        if (accepted) begin
            q_data.push_back(has_exp ? ed : mdl_data(d, int'(s)));
            q_sticky.push_back(has_exp ? es : mdl_sticky(d, int'(s)));
            q_tag.push_back(t);
            q_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 8'd0, 8'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    logic [31:0] dir_d  [8] = '{32'h8000_0000, 32'h0000_00FF, 32'h0000_00F0, 32'h1234_5678,
                                32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
    logic [7:0]  dir_s  [8] = '{8'd31, 8'd4, 8'd4, 8'd0, 8'd40, 8'd200, 8'd32, 8'd255};
    logic [31:0] dir_ed [8] = '{32'h0000_0001, 32'h0000_000F, 32'h0000_000F, 32'h1234_5678,
                                32'h0, 32'h0, 32'h0, 32'h0};
    logic        dir_es [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int          i;
        int          n;
        logic        v;
        logic        ordy;
        logic [31:0] d;
        logic [7:0]  s;

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sticky", out_sticky, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary values, back-to-back with fixed latency
        lat_chk = 1'b1;
        for (int k = 0; k < 8; k++)
            cycle(1'b1, dir_d[k], dir_s[k], 8'(8'h10 + k), 1'b1, 1'b1, dir_ed[k], dir_es[k]);
        idle(6);
        chk("directed_drain", q_data.size(), 0);
        lat_chk = 1'b0;

        // Stream of 8 all-ones items with a 3-cycle stall after the 2nd result
        i = 0;
        ir_low = 0;
        for (int c = 0; c < 40 && (i < 8 || q_data.size() != 0); c++) begin
            ordy = !(c >= 7 && c <= 9);
            v    = (i < 8);
            cycle(v, 32'hFFFF_FFFF, 8'(i), 8'(i), ordy, 1'b1, 32'hFFFF_FFFF >> i, (i != 0));
            if (accepted) i++;
        end
        chk("stream_sent", i, 8);
        chk("stream_drain", q_data.size(), 0);
        chk("stream_in_ready_low", ir_low, 3);

        // Random traffic against the model
        n = 0;
        for (int c = 0; c < 60000 && n < 10000; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            s    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 40));
            cycle(v, d, s, 8'($urandom), ordy, 1'b0, 32'd0, 1'b0);
            if (accepted) n++;
        end
        chk("rand_accepted", n, 10000);
        for (int c = 0; c < 20 && q_data.size() != 0; c++) idle(1);
        chk("rand_drain", q_data.size(), 0);

        // Asynchronous reset with items in flight and one on the output
        for (int k = 0; k < 6; k++)
            cycle(1'b1, $urandom, 8'($urandom_range(0, 31)), 8'(k), 1'b1, 1'b0, 32'd0, 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_tag", out_tag, 0);
        chk("async_rst_in_ready", in_ready, 1);
        q_data.delete();
        q_sticky.delete();
        q_tag.delete();
        q_cyc.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        chk("post_reset_empty", q_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
